// File: rtl/uart_tx_fifo_feeder.sv
// uart_tx_fifo_feeder: byte FIFO that hands one byte per frame to a UART TX
// serializer and issues a one-cycle start pulse for each frame.
//
// Ports:
//   clk                 sole clock, rising edge
//   rst_n               synchronous active-low reset
//   wr_en, wr_data      host write strobe and byte (one byte per cycle)
//   flush               empties the FIFO; a frame already started is unaffected
//   clr_overflow        clears the sticky overflow flag
//   cfg_channel_enable  channel enable shared with the serializer
//   is_transmitting     serializer busy flag
//   tx_byte             byte presented to the serializer, held until next pop
//   transmit            one-cycle start pulse to the serializer
//   fifo_full/empty     FIFO status, decoded from fifo_level
//   fifo_level          entries held, 0..DEPTH
//   overflow            sticky flag, set by a write while full
//   tx_busy             high while a frame is being handed off or in progress
module uart_tx_fifo_feeder #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  input  logic          clr_overflow,
  input  logic          cfg_channel_enable,
  input  logic          is_transmitting,
  output logic [7:0]    tx_byte,
  output logic          transmit,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic [AW:0]   fifo_level,
  output logic          overflow,
  output logic          tx_busy
);

  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            transmit_nxt;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  logic            pop;
  logic            push;
  logic            drop;

  // Status decoded from the registered level counter
  assign fifo_full  = (fifo_level == LW'(DEPTH));
  assign fifo_empty = (fifo_level == '0);
  assign tx_busy    = (state != IDLE);

  // A pop frees a slot in the same cycle, so a write at full is accepted
  // when it coincides with a pop. Flush suppresses both.
  assign pop  = (state == IDLE) && !fifo_empty && cfg_channel_enable &&
                !is_transmitting && !flush;
  assign push = wr_en && !flush && (!fifo_full || pop);
  assign drop = wr_en && !flush && fifo_full && !pop;

  // Storage array; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, level, overflow and the presented byte
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      tx_byte    <= 8'h00;
    end else begin
      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_level <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        case ({push, pop})
          2'b10:   fifo_level <= fifo_level + LW'(1);
          2'b01:   fifo_level <= fifo_level - LW'(1);
          default: fifo_level <= fifo_level;
        endcase
      end

      // A dropped write wins over a coincident clear
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end

      if (pop) begin
        tx_byte <= mem[rd_ptr];
      end
    end
  end

  // FSM state and start-pulse register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      transmit <= 1'b0;
    end else begin
      state    <= state_nxt;
      transmit <= transmit_nxt;
    end
  end

  // Next-state logic; the start pulse is only raised on the pop edge
  always_comb begin
    state_nxt    = state;
    transmit_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (pop) begin
          state_nxt    = WAIT_BUSY;
          transmit_nxt = 1'b1;
        end
      end
      WAIT_BUSY: begin
        if (!cfg_channel_enable) begin
          state_nxt = IDLE;
        end else if (is_transmitting) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!cfg_channel_enable || !is_transmitting) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Testbench for uart_tx_fifo_feeder: directed scenarios plus a randomized
// run, checked against a queue-based reference model and a simple serializer.
module tb_uart_tx_fifo_feeder;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned LW    = AW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          flush = 1'b0;
  logic          clr_overflow = 1'b0;
  logic          cfg_channel_enable = 1'b0;
  logic          is_transmitting = 1'b0;
  logic [7:0]    tx_byte;
  logic          transmit;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW:0]   fifo_level;
  logic          overflow;
  logic          tx_busy;

  always #5 clk = ~clk;

  uart_tx_fifo_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .wr_en              (wr_en),
    .wr_data            (wr_data),
    .flush              (flush),
    .clr_overflow       (clr_overflow),
    .cfg_channel_enable (cfg_channel_enable),
    .is_transmitting    (is_transmitting),
    .tx_byte            (tx_byte),
    .transmit           (transmit),
    .fifo_full          (fifo_full),
    .fifo_empty         (fifo_empty),
    .fifo_level         (fifo_level),
    .overflow           (overflow),
    .tx_busy            (tx_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queued bytes, sticky flag, and frame-in-progress status
  logic [7:0] q[$];
  logic [7:0] m_tx_byte = 8'h00;
  bit         m_transmit = 0;
  bit         m_ovf = 0;
  bit         m_busy = 0;
  bit         m_seen = 0;

  // Serializer stand-in: busy for ser_len cycles starting one cycle after a start
  int  ser_cnt = 0;
  int  ser_len = 10;
  bit  ser_auto = 1;
  bit  ser_rand = 0;

  logic [7:0] sent[$];
  bit         drain_to;

  task automatic model_step();
    bit start;
    bit was_full;
    if (!rst_n) begin
      q.delete();
      m_ovf = 0; m_busy = 0; m_seen = 0; m_transmit = 0; m_tx_byte = 8'h00;
      return;
    end
    was_full = (q.size() == DEPTH);
    start = !m_busy && (q.size() != 0) && cfg_channel_enable &&
            !is_transmitting && !flush;
    if (m_busy) begin
      if (!cfg_channel_enable) m_busy = 0;
      else if (!m_seen) begin
        if (is_transmitting) m_seen = 1;
      end else if (!is_transmitting) m_busy = 0;
    end
    m_transmit = start;
    if (start) begin
      m_tx_byte = q.pop_front();
      m_busy = 1;
      m_seen = 0;
    end
    if (flush) q.delete();
    else if (wr_en) begin
      if (was_full && !start) m_ovf = 1;
      else q.push_back(wr_data);
    end
    if (!(flush == 0 && wr_en && was_full && !start) && clr_overflow) m_ovf = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    if (ser_auto) begin
      if (m_transmit) ser_cnt = ser_rand ? int'($urandom_range(1, 4)) : ser_len;
      else if (ser_cnt > 0) ser_cnt--;
      is_transmitting = (ser_cnt > 0);
    end
  endtask

  // Run until model and serializer are idle, collecting bytes the DUT starts
  task automatic drain(input int max_cycles);
    sent.delete();
    drain_to = 1;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (transmit === 1'b1) sent.push_back(tx_byte);
      if (!m_busy && q.size() == 0 && ser_cnt == 0) begin
        drain_to = 0;
        break;
      end
    end
  endtask

  task automatic write_bytes(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      wr_en = 1; wr_data = base + 8'(i);
      tick();
    end
    wr_en = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; wr_en = 1; wr_data = 8'hFF; cfg_channel_enable = 1;
    tick(); tick();
    wr_en = 0;
    n_tests++;
    if ({tx_byte, transmit, overflow, tx_busy} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs got tx_byte=%h transmit=%b ovf=%b busy=%b exp 00 0 0 0",
               tx_byte, transmit, overflow, tx_busy);
    end
    n_tests++;
    if ({fifo_level, fifo_empty, fifo_full} !== {LW'(0), 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_status got level=%0d empty=%b full=%b exp 0 1 0",
               fifo_level, fifo_empty, fifo_full);
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_single();
    int extra;
    cfg_channel_enable = 1;
    wr_en = 1; wr_data = 8'hA5;
    tick();
    wr_en = 0;
    n_tests++;
    if (fifo_level !== LW'(1) || transmit !== 1'b0) begin
      n_fail++;
      $display("FAIL single_after_write got level=%0d transmit=%b exp 1 0", fifo_level, transmit);
    end
    tick();
    n_tests++;
    if ({transmit, tx_byte, fifo_level, tx_busy} !== {1'b1, 8'hA5, LW'(0), 1'b1}) begin
      n_fail++;
      $display("FAIL single_pop got transmit=%b tx_byte=%h level=%0d busy=%b exp 1 a5 0 1",
               transmit, tx_byte, fifo_level, tx_busy);
    end
    extra = 0;
    for (int i = 0; i < 40 && is_transmitting !== 1'b0 || i == 0; i++) begin
      tick();
      if (transmit === 1'b1) extra++;
    end
    tick();
    if (transmit === 1'b1) extra++;
    n_tests++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL single_one_pulse got %0d extra pulses exp 0", extra);
    end
    n_tests++;
    if (tx_busy !== 1'b0 || tx_byte !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_done got busy=%b tx_byte=%h exp 0 a5", tx_busy, tx_byte);
    end
  endtask

  task automatic test_fill_overflow();
    bit bad;
    cfg_channel_enable = 0;
    for (int i = 0; i < 17; i++) begin
      wr_en = 1; wr_data = 8'(i);
      tick();
      if (i == 15) begin
        n_tests++;
        if ({fifo_full, fifo_level, overflow} !== {1'b1, LW'(16), 1'b0}) begin
          n_fail++;
          $display("FAIL fill_16th got full=%b level=%0d ovf=%b exp 1 16 0",
                   fifo_full, fifo_level, overflow);
        end
      end
    end
    wr_en = 0;
    n_tests++;
    if ({fifo_full, fifo_level, overflow} !== {1'b1, LW'(16), 1'b1}) begin
      n_fail++;
      $display("FAIL fill_17th got full=%b level=%0d ovf=%b exp 1 16 1",
               fifo_full, fifo_level, overflow);
    end
    cfg_channel_enable = 1;
    drain(800);
    bad = drain_to || sent.size() != 16;
    for (int i = 0; i < sent.size() && i < 16; i++) if (sent[i] !== 8'(i)) bad = 1;
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL fill_drain_order got %0d bytes (timeout=%b) first=%h exp 16 bytes 00..0f",
               sent.size(), drain_to, sent.size() > 0 ? sent[0] : 8'hxx);
    end
    n_tests++;
    if (overflow !== 1'b1 || fifo_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky got ovf=%b empty=%b exp 1 1", overflow, fifo_empty);
    end
    clr_overflow = 1;
    tick();
    clr_overflow = 0;
    n_tests++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear got %b exp 0", overflow);
    end
  endtask

  task automatic test_wr_pop_same_cycle();
    logic [7:0] exp_q[$];
    bit bad;
    cfg_channel_enable = 0;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; wr_data = 8'($urandom);
      exp_q.push_back(wr_data);
      tick();
    end
    cfg_channel_enable = 1; wr_en = 1; wr_data = 8'hC3;
    exp_q.push_back(8'hC3);
    tick();
    wr_en = 0;
    n_tests++;
    if ({fifo_level, overflow, transmit, tx_byte} !== {LW'(16), 1'b0, 1'b1, exp_q[0]}) begin
      n_fail++;
      $display("FAIL full_wr_pop got level=%0d ovf=%b transmit=%b tx_byte=%h exp 16 0 1 %h",
               fifo_level, overflow, transmit, tx_byte, exp_q[0]);
    end
    void'(exp_q.pop_front());
    drain(800);
    bad = drain_to || sent.size() != exp_q.size();
    for (int i = 0; i < sent.size() && i < exp_q.size(); i++) if (sent[i] !== exp_q[i]) bad = 1;
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL full_wrap_data got %0d bytes (timeout=%b) exp %0d matching bytes",
               sent.size(), drain_to, exp_q.size());
    end
    cfg_channel_enable = 0;
    wr_en = 1; wr_data = 8'h5A;
    tick();
    cfg_channel_enable = 1; wr_data = 8'h96;
    tick();
    wr_en = 0;
    n_tests++;
    if ({fifo_level, transmit, tx_byte} !== {LW'(1), 1'b1, 8'h5A}) begin
      n_fail++;
      $display("FAIL lvl1_wr_pop got level=%0d transmit=%b tx_byte=%h exp 1 1 5a",
               fifo_level, transmit, tx_byte);
    end
    drain(200);
    n_tests++;
    if (drain_to || sent.size() != 1 || sent[0] !== 8'h96) begin
      n_fail++;
      $display("FAIL lvl1_next_byte got %0d bytes first=%h exp 1 byte 96",
               sent.size(), sent.size() > 0 ? sent[0] : 8'hxx);
    end
  endtask

  task automatic test_disable_midframe();
    cfg_channel_enable = 0;
    write_bytes(3, 8'h11);
    cfg_channel_enable = 1;
    tick(); tick(); tick();
    cfg_channel_enable = 0;
    tick();
    n_tests++;
    if ({tx_busy, transmit, fifo_level} !== {1'b0, 1'b0, LW'(2)}) begin
      n_fail++;
      $display("FAIL disable_idle got busy=%b transmit=%b level=%0d exp 0 0 2",
               tx_busy, transmit, fifo_level);
    end
    cfg_channel_enable = 1;
    drain(300);
    n_tests++;
    if (drain_to || sent.size() != 2 || sent[0] !== 8'h12 || sent[1] !== 8'h13) begin
      n_fail++;
      $display("FAIL disable_resume got %0d bytes first=%h exp 12 13",
               sent.size(), sent.size() > 0 ? sent[0] : 8'hxx);
    end
  endtask

  task automatic test_flush();
    cfg_channel_enable = 0;
    write_bytes(6, 8'h40);
    cfg_channel_enable = 1;
    tick(); tick(); tick();
    n_tests++;
    if (fifo_level !== LW'(5) || tx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_setup got level=%0d busy=%b exp 5 1", fifo_level, tx_busy);
    end
    flush = 1; wr_en = 1; wr_data = 8'hEE;
    tick();
    flush = 0; wr_en = 0;
    n_tests++;
    if ({fifo_level, fifo_empty, tx_busy, tx_byte} !== {LW'(0), 1'b1, 1'b1, 8'h40}) begin
      n_fail++;
      $display("FAIL flush_clear got level=%0d empty=%b busy=%b tx_byte=%h exp 0 1 1 40",
               fifo_level, fifo_empty, tx_busy, tx_byte);
    end
    drain(300);
    n_tests++;
    if (drain_to || sent.size() != 0 || tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_no_more got %0d pulses busy=%b exp 0 0", sent.size(), tx_busy);
    end
  endtask

  task automatic test_reset_midframe();
    int pulses;
    cfg_channel_enable = 0;
    write_bytes(4, 8'h70);
    cfg_channel_enable = 1;
    tick(); tick(); tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    n_tests++;
    if ({tx_byte, transmit, fifo_level, fifo_empty, fifo_full, overflow, tx_busy} !==
        {8'h00, 1'b0, LW'(0), 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midframe_reset got tx_byte=%h transmit=%b level=%0d busy=%b exp 00 0 0 0",
               tx_byte, transmit, fifo_level, tx_busy);
    end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (transmit === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL midframe_quiet got %0d pulses exp 0", pulses);
    end
    write_bytes(1, 8'h77);
    drain(100);
    n_tests++;
    if (drain_to || sent.size() != 1 || sent[0] !== 8'h77) begin
      n_fail++;
      $display("FAIL midframe_new_write got %0d bytes first=%h exp 1 byte 77",
               sent.size(), sent.size() > 0 ? sent[0] : 8'hxx);
    end
  endtask

  task automatic test_random();
    logic [17:0] got;
    logic [17:0] exp;
    int shown = 0;
    ser_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      wr_en              = ($urandom_range(0, 99) < 45);
      wr_data            = 8'($urandom);
      cfg_channel_enable = ($urandom_range(0, 99) < 92);
      flush              = ($urandom_range(0, 99) < 2);
      clr_overflow       = ($urandom_range(0, 99) < 5);
      tick();
      got = {tx_byte, transmit, fifo_level, fifo_empty, fifo_full, overflow, tx_busy};
      exp = {m_tx_byte, m_transmit, LW'(q.size()), q.size() == 0, q.size() == DEPTH, m_ovf, m_busy};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        if (shown < 20) begin
          shown++;
          $display("FAIL random_cycle_%0d got %h exp %h (byte,tx,level,empty,full,ovf,busy)",
                   i, got, exp);
        end
      end
    end
    wr_en = 0; flush = 0; clr_overflow = 0;
    ser_rand = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_wr_pop_same_cycle();
    test_disable_midframe();
    test_flush();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
